// File: rtl/cspwm_sequencer.sv
// Start-up/shutdown sequencer for the three-module carrier-shifted PWM stage.
// Generates the carrier sync pulse, phase offsets, PWM enable and a slew-limited target voltage.
module cspwm_sequencer #(
  parameter int unsigned RAMP_STEP     = 16,
  parameter logic [15:0] UDC_MIN       = 16'd1000,
  parameter int unsigned ALIGN_PERIODS = 4
) (
  input  logic               clk_20M,
  input  logic               reset,
  input  logic               enable_cmd,
  input  logic               clear_trip,
  input  logic [15:0]        Frequency,
  input  logic signed [15:0] TargetVol_cmd,
  input  logic [15:0]        LinkUdcA,
  input  logic [15:0]        LinkUdcB,
  input  logic [15:0]        LinkUdcC,
  input  logic [15:0]        Udc_limit,
  output logic               Syn,
  output logic               start,
  output logic signed [15:0] TargetVol,
  output logic [15:0]        Angle_initialA,
  output logic [15:0]        Angle_initialB,
  output logic [15:0]        Angle_initialC,
  output logic [2:0]         state,
  output logic               trip
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StAlign = 3'd2,
    StRamp  = 3'd3,
    StRun   = 3'd4,
    StStop  = 3'd5,
    StTrip  = 3'd6
  } state_e;

  localparam logic [15:0] Step      = 16'(RAMP_STEP);
  localparam logic [15:0] AlignLast = 16'(ALIGN_PERIODS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        syn_q, syn_d;
  logic [15:0] align_q, align_d;
  logic [15:0] angle_b_q, angle_b_d, angle_c_q, angle_c_d;
  logic        start_q, start_d;
  logic        trip_q, trip_d;
  logic [15:0] tv_q, tv_d;

  logic freq_ok, over_volt, udc_ok;

  assign freq_ok   = (Frequency >= 16'd3);
  assign over_volt = (LinkUdcA > Udc_limit) || (LinkUdcB > Udc_limit) || (LinkUdcC > Udc_limit);
  assign udc_ok    = (LinkUdcA >= UDC_MIN) && (LinkUdcB >= UDC_MIN) && (LinkUdcC >= UDC_MIN);

  // One slew step from cur toward tgt; the 17-bit difference keeps full-scale swings from wrapping.
  function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt);
    logic [16:0] diff, mag;
    diff = {tgt[15], tgt} - {cur[15], cur};
    mag  = diff[16] ? (17'd0 - diff) : diff;
    if (mag <= {1'b0, Step}) begin
      return tgt;
    end else if (diff[16]) begin
      return 16'({cur[15], cur} - {1'b0, Step});
    end else begin
      return 16'({cur[15], cur} + {1'b0, Step});
    end
  endfunction

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!freq_ok || (cnt_q >= Frequency - 16'd1)) begin
      cnt_d = 16'd0;
    end
    syn_d = freq_ok && (cnt_q == 16'd0);

    angle_b_d = angle_b_q;
    angle_c_d = angle_c_q;
    if (state_q == StIdle) begin
      angle_b_d = 16'((32'(Frequency) * 32'd21846) >> 16);
      angle_c_d = 16'((32'(Frequency) * 32'd43691) >> 16);
    end

    align_d = 16'd0;
    if (state_q == StAlign) begin
      align_d = syn_q ? align_q + 16'd1 : align_q;
    end
  end

  // State register
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      syn_q     <= 1'b0;
      align_q   <= 16'd0;
      angle_b_q <= 16'd0;
      angle_c_q <= 16'd0;
      start_q   <= 1'b0;
      trip_q    <= 1'b0;
      tv_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      syn_q     <= syn_d;
      align_q   <= align_d;
      angle_b_q <= angle_b_d;
      angle_c_q <= angle_c_d;
      start_q   <= start_d;
      trip_q    <= trip_d;
      tv_q      <= tv_d;
    end
  end

  // Next-state logic; overvoltage outranks every other exit outside IDLE and TRIP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable_cmd && freq_ok) state_d = StCheck;
      StCheck: begin
        if (over_volt)        state_d = StTrip;
        else if (!enable_cmd) state_d = StIdle;
        else if (udc_ok)      state_d = StAlign;
      end
      StAlign: begin
        if (over_volt)                           state_d = StTrip;
        else if (!enable_cmd)                    state_d = StIdle;
        else if (syn_q && (align_q == AlignLast)) state_d = StRamp;
      end
      StRamp: begin
        if (over_volt)                    state_d = StTrip;
        else if (!enable_cmd)             state_d = StStop;
        else if (tv_q == TargetVol_cmd)   state_d = StRun;
      end
      StRun: begin
        if (over_volt)        state_d = StTrip;
        else if (!enable_cmd) state_d = StStop;
      end
      StStop: begin
        if (over_volt)             state_d = StTrip;
        else if (tv_q == 16'd0)    state_d = StIdle;
      end
      StTrip:  if (clear_trip && !enable_cmd) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic, registered alongside the state so all of them move together.
  always_comb begin
    start_d = (state_d == StRamp) || (state_d == StRun) || (state_d == StStop);
    trip_d  = (state_d == StTrip);
    tv_d    = tv_q;
    if ((state_d == StIdle) || (state_d == StTrip)) begin
      tv_d = 16'd0;
    end else if (syn_q) begin
      if ((state_q == StRamp) || (state_q == StRun)) begin
        tv_d = slew(tv_q, TargetVol_cmd);
      end else if (state_q == StStop) begin
        tv_d = slew(tv_q, 16'd0);
      end
    end
  end

  assign Syn            = syn_q;
  assign start          = start_q;
  assign TargetVol      = tv_q;
  assign Angle_initialA = 16'd0;
  assign Angle_initialB = angle_b_q;
  assign Angle_initialC = angle_c_q;
  assign state          = state_q;
  assign trip           = trip_q;

endmodule

// File: tb/tb_cspwm_sequencer.sv
// Scoreboard bench for cspwm_sequencer: expected output-change trace plus directed spot checks.
module tb_cspwm_sequencer;

  logic               clk_20M = 1'b0;
  logic               reset = 1'b1;
  logic               enable_cmd = 1'b0;
  logic               clear_trip = 1'b0;
  logic [15:0]        Frequency = 16'd1000;
  logic signed [15:0] cmd1 = 16'sd100;
  logic signed [15:0] cmd2 = 16'sd32767;
  logic [15:0]        LinkUdcA = 16'd1200, LinkUdcB = 16'd1200, LinkUdcC = 16'd1200;
  logic [15:0]        Udc_limit = 16'd2000;

  logic               syn1, start1, trip1, syn2, start2, trip2;
  logic signed [15:0] tv1, tv2;
  logic [15:0]        ang_a1, ang_b1, ang_c1, ang_a2, ang_b2, ang_c2;
  logic [2:0]         state1, state2;

  always #25 clk_20M = ~clk_20M;

  cspwm_sequencer #(.RAMP_STEP(16), .UDC_MIN(16'd1000), .ALIGN_PERIODS(4)) u_dut (
    .clk_20M(clk_20M), .reset(reset), .enable_cmd(enable_cmd), .clear_trip(clear_trip),
    .Frequency(Frequency), .TargetVol_cmd(cmd1), .LinkUdcA(LinkUdcA), .LinkUdcB(LinkUdcB),
    .LinkUdcC(LinkUdcC), .Udc_limit(Udc_limit), .Syn(syn1), .start(start1), .TargetVol(tv1),
    .Angle_initialA(ang_a1), .Angle_initialB(ang_b1), .Angle_initialC(ang_c1), .state(state1),
    .trip(trip1)
  );

  // Second instance exercises a step wider than half the signed range.
  cspwm_sequencer #(.RAMP_STEP(40000), .UDC_MIN(16'd1000), .ALIGN_PERIODS(4)) u_dut_wide (
    .clk_20M(clk_20M), .reset(reset), .enable_cmd(enable_cmd), .clear_trip(clear_trip),
    .Frequency(Frequency), .TargetVol_cmd(cmd2), .LinkUdcA(LinkUdcA), .LinkUdcB(LinkUdcB),
    .LinkUdcC(LinkUdcC), .Udc_limit(Udc_limit), .Syn(syn2), .start(start2), .TargetVol(tv2),
    .Angle_initialA(ang_a2), .Angle_initialB(ang_b2), .Angle_initialC(ang_c2), .state(state2),
    .trip(trip2)
  );

  // Scoreboard queues: trace of expected {state,start,TargetVol,trip} changes, and spot checks.
  logic [20:0] tq[$];
  string       dq_name[$];
  int          dq_act[$];
  int          dq_exp[$];
  bit          mon_on = 1'b0;
  bit          done = 1'b0;
  int          passed = 0;
  int          total = 0;

  task automatic push_t(input logic [2:0] s, input bit st, input int tv, input bit tr);
    logic [15:0] v;
    v = tv[15:0];
    tq.push_back({s, st, v, tr});
  endtask

  task automatic push_chk(input string name, input int act, input int exp);
    dq_name.push_back(name);
    dq_act.push_back(act);
    dq_exp.push_back(exp);
  endtask

  task automatic push_ramp_up();
    push_t(3'd3, 1'b1, 0, 1'b0);
    for (int v = 16; v < 100; v += 16) push_t(3'd3, 1'b1, v, 1'b0);
    push_t(3'd3, 1'b1, 100, 1'b0);
    push_t(3'd4, 1'b1, 100, 1'b0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max);
    int n;
    n = 0;
    while (state1 !== s && n < max) begin
      @(negedge clk_20M);
      n++;
    end
    push_chk("wait_state", int'(state1), int'(s));
  endtask

  // Returns on the cycle after a Syn-high cycle, when the step is visible.
  task automatic wait_syn();
    int n;
    n = 0;
    @(negedge clk_20M);
    while (!syn1 && n < 100) begin
      @(negedge clk_20M);
      n++;
    end
    push_chk("syn_wait_in_budget", int'(n < 100), 1);
    @(negedge clk_20M);
  endtask

  // Monitor: compares every change of the output tuple against the trace queue.
  initial begin
    logic [20:0] cur, prev, e;
    int cycles;
    int tidx;
    cycles = 0;
    tidx = 0;
    prev = 21'd0;
    forever begin
      @(negedge clk_20M);
      cycles++;
      while (dq_name.size() > 0) begin
        string nm;
        int a, x;
        nm = dq_name.pop_front();
        a = dq_act.pop_front();
        x = dq_exp.pop_front();
        total++;
        if (a == x) passed++;
        else $display("FAIL %s: got %0d, required %0d", nm, a, x);
      end
      if (mon_on) begin
        cur = {state1, start1, tv1, trip1};
        if (cur !== prev) begin
          total++;
          if (tq.size() == 0) begin
            $display("FAIL trace[%0d]: got state=%0d start=%0b tv=%0d trip=%0b, required no change",
                     tidx, cur[20:18], cur[17], $signed(cur[16:1]), cur[0]);
          end else begin
            e = tq.pop_front();
            if (cur === e) passed++;
            else $display("FAIL trace[%0d]: got state=%0d start=%0b tv=%0d trip=%0b, required state=%0d start=%0b tv=%0d trip=%0b",
                          tidx, cur[20:18], cur[17], $signed(cur[16:1]), cur[0],
                          e[20:18], e[17], $signed(e[16:1]), e[0]);
          end
          tidx++;
          prev = cur;
        end
      end
      if (cycles > 90000) begin
        total++;
        $display("FAIL watchdog: got %0d cycles, required completion", cycles);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
      end
      if (done) begin
        total++;
        if (tq.size() == 0) passed++;
        else $display("FAIL trace_leftover: got %0d pending, required 0", tq.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
      end
    end
  end

  initial begin
    int n, k;
    // Reset state
    repeat (2) @(negedge clk_20M);
    mon_on = 1'b1;
    push_chk("rst_state", int'(state1), 0);
    push_chk("rst_start", int'(start1), 0);
    push_chk("rst_tv", int'(tv1), 0);
    push_chk("rst_trip", int'(trip1), 0);
    push_chk("rst_syn", int'(syn1), 0);
    push_chk("rst_angle_b", int'(ang_b1), 0);
    reset = 1'b0;

    // Syn period and IDLE phase offsets at Frequency=1000
    n = 0;
    while (!syn1 && n < 2000) begin
      @(negedge clk_20M);
      n++;
    end
    n = 0;
    @(negedge clk_20M);
    n++;
    while (!syn1 && n < 2000) begin
      @(negedge clk_20M);
      n++;
    end
    push_chk("syn_period", n, 1000);
    push_chk("angle_a", int'(ang_a1), 0);
    push_chk("angle_b", int'(ang_b1), 333);
    push_chk("angle_c", int'(ang_c1), 666);

    // Precharge not met holds CHECK; raising B to UDC_MIN releases it
    Frequency = 16'd20;
    LinkUdcB = 16'd900;
    push_t(3'd1, 1'b0, 0, 1'b0);
    enable_cmd = 1'b1;
    repeat (30) @(negedge clk_20M);
    push_chk("precharge_hold_state", int'(state1), 1);
    push_chk("precharge_hold_start", int'(start1), 0);
    push_t(3'd2, 1'b0, 0, 1'b0);
    push_ramp_up();
    LinkUdcB = 16'd1000;
    wait_state(3'd2, 10);
    n = 0;
    k = 0;
    while (!start1 && k < 500) begin
      if (syn1) n++;
      @(negedge clk_20M);
      k++;
    end
    push_chk("align_syn_pulses", n, 4);
    wait_state(3'd4, 1000);
    push_chk("run_tv", int'(tv1), 100);

    // Full-scale swing on the wide-step instance
    push_chk("wide_run_tv", int'(tv2), 32767);
    push_chk("wide_run_state", int'(state2), 4);
    wait_syn();
    cmd2 = -16'sd32768;
    wait_syn();
    push_chk("wide_step1", int'(tv2), -7233);
    wait_syn();
    push_chk("wide_step2", int'(tv2), -32768);

    // Stop: 6 steps of 16, then 4, then IDLE
    push_t(3'd5, 1'b1, 100, 1'b0);
    for (int v = 84; v > 0; v -= 16) push_t(3'd5, 1'b1, v, 1'b0);
    push_t(3'd5, 1'b1, 0, 1'b0);
    push_t(3'd0, 1'b0, 0, 1'b0);
    enable_cmd = 1'b0;
    wait_state(3'd0, 1000);
    push_chk("stop_start", int'(start1), 0);

    // Trip during RAMP
    push_t(3'd1, 1'b0, 0, 1'b0);
    push_t(3'd2, 1'b0, 0, 1'b0);
    push_t(3'd3, 1'b1, 0, 1'b0);
    push_t(3'd3, 1'b1, 16, 1'b0);
    push_t(3'd6, 1'b0, 0, 1'b1);
    enable_cmd = 1'b1;
    k = 0;
    while (!(state1 == 3'd3 && tv1 == 16'sd16) && k < 1000) begin
      @(negedge clk_20M);
      k++;
    end
    push_chk("pre_trip_tv", int'(tv1), 16);
    LinkUdcC = 16'd2001;
    @(negedge clk_20M);
    push_chk("trip_state", int'(state1), 6);
    push_chk("trip_flag", int'(trip1), 1);
    clear_trip = 1'b1;
    repeat (10) @(negedge clk_20M);
    push_chk("trip_hold_with_enable", int'(state1), 6);
    push_t(3'd0, 1'b0, 0, 1'b0);
    LinkUdcC = 16'd1200;
    enable_cmd = 1'b0;
    repeat (2) @(negedge clk_20M);
    push_chk("trip_cleared", int'(trip1), 0);
    clear_trip = 1'b0;

    // Frequency below 3: no Syn, enable ignored
    Frequency = 16'd2;
    enable_cmd = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_20M);
      if (syn1) n++;
    end
    push_chk("low_freq_syn_count", n, 0);
    push_chk("low_freq_state", int'(state1), 0);
    push_chk("low_freq_angle_b", int'(ang_b1), 0);
    push_chk("low_freq_angle_c", int'(ang_c1), 1);
    enable_cmd = 1'b0;
    @(negedge clk_20M);
    Frequency = 16'd20;
    @(negedge clk_20M);

    // Reset asserted in RUN
    push_t(3'd1, 1'b0, 0, 1'b0);
    push_t(3'd2, 1'b0, 0, 1'b0);
    push_ramp_up();
    enable_cmd = 1'b1;
    wait_state(3'd4, 2000);
    push_t(3'd0, 1'b0, 0, 1'b0);
    reset = 1'b1;
    enable_cmd = 1'b0;
    @(negedge clk_20M);
    push_chk("mid_rst_state", int'(state1), 0);
    push_chk("mid_rst_start", int'(start1), 0);
    push_chk("mid_rst_tv", int'(tv1), 0);
    push_chk("mid_rst_syn", int'(syn1), 0);
    push_chk("mid_rst_angle_c", int'(ang_c1), 0);
    push_chk("mid_rst_wide_tv", int'(tv2), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_20M);
    done = 1'b1;
  end

endmodule
